// File: rtl/mic_pkg.sv
// Shared types and constants for the MEMS microphone clock / PDM capture controller.
package mic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAKE = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } mic_state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DIV    = 2'd1;
    localparam logic [1:0] ADDR_WAKE   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int          DIV_RST  = 3;
    localparam logic [15:0] WAKE_RST = 16'h0400;

endpackage

// File: rtl/mic_clk_div.sv
// Half-period divider for micclk; toggles only on terminal count, so no runt pulses.
module mic_clk_div
    import mic_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] limit_act,
    output logic             micclk,
    output logic             tgl,
    output logic             rise,
    output logic             fall
);

    logic [CNT_W-1:0] cnt;

    assign tgl  = run && (cnt == limit_act);
    assign rise = tgl && !micclk;
    assign fall = tgl && micclk;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt    <= '0;
            micclk <= 1'b0;
        end else if (tgl) begin
            cnt    <= '0;
            micclk <= ~micclk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mic_clk_ctrl.sv
// Microphone clock controller: register file, wake/run/stop sequencing and stereo PDM capture.
//   state | meaning
//   IDLE  | divider held, micclk low
//   WAKE  | micclk running, counting rising edges until the mics settle
//   RUN   | micclk running, PDM capture enabled
//   STOP  | finishing the current high phase before going idle
module mic_clk_ctrl
    import mic_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int WAKE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    output logic [15:0] cfg_rdata,
    input  logic        pdm_in,
    output logic        micclk,
    output logic        bit_l,
    output logic        bit_r,
    output logic        valid_l,
    output logic        valid_r,
    output logic        running
);

    mic_state_t        state, state_nxt;
    logic              ctrl_en;
    logic [CNT_W-1:0]  div_shadow, limit_act;
    logic [WAKE_W-1:0] wake_reg, wake_cnt;
    logic [WAKE_W:0]   wake_nxt;
    logic              tgl, rise, fall;
    logic              wake_clr, wake_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en    <= 1'b0;
            div_shadow <= CNT_W'(DIV_RST);
            wake_reg   <= WAKE_W'(WAKE_RST);
        end else if (cfg_we) begin
            case (cfg_addr)
                ADDR_CTRL: ctrl_en    <= cfg_wdata[0];
                ADDR_DIV:  div_shadow <= cfg_wdata[CNT_W-1:0];
                ADDR_WAKE: wake_reg   <= cfg_wdata[WAKE_W-1:0];
                default:   ;
            endcase
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_CTRL: cfg_rdata[0]          = ctrl_en;
            ADDR_DIV:  cfg_rdata[CNT_W-1:0]  = div_shadow;
            ADDR_WAKE: cfg_rdata[WAKE_W-1:0] = wake_reg;
            default:   cfg_rdata[2:0]        = {state == ST_STOP, state == ST_WAKE, state == ST_RUN};
        endcase
    end

    // A new divide ratio only lands on a toggle edge, so the current half-period completes untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            limit_act <= CNT_W'(DIV_RST);
        end else if (state == ST_IDLE || tgl) begin
            limit_act <= div_shadow;
        end
    end

    mic_clk_div #(.CNT_W(CNT_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .run       (state != ST_IDLE),
        .limit_act (limit_act),
        .micclk    (micclk),
        .tgl       (tgl),
        .rise      (rise),
        .fall      (fall)
    );

    assign wake_nxt = {1'b0, wake_cnt} + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wake_clr  = 1'b0;
        wake_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ctrl_en) begin
                    wake_clr  = 1'b1;
                    state_nxt = (wake_reg == '0) ? ST_RUN : ST_WAKE;
                end
            end
            ST_WAKE, ST_RUN: begin
                if (!ctrl_en) begin
                    state_nxt = (!micclk && !tgl) ? ST_IDLE : ST_STOP;
                end else if (state == ST_WAKE && rise) begin
                    wake_inc = 1'b1;
                    if (wake_nxt >= {1'b0, wake_reg}) state_nxt = ST_RUN;
                end
            end
            default: begin
                if (ctrl_en) begin
                    wake_clr  = 1'b1;
                    state_nxt = ST_WAKE;
                end else if (fall) begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || wake_clr) begin
            wake_cnt <= '0;
        end else if (wake_inc) begin
            wake_cnt <= wake_nxt[WAKE_W-1:0];
        end
    end

    // Gating on ctrl_en keeps a disable write from letting one more strobe slip out.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_l   <= 1'b0;
            bit_r   <= 1'b0;
            valid_l <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            valid_l <= 1'b0;
            valid_r <= 1'b0;
            if (state == ST_RUN && ctrl_en) begin
                if (fall) begin
                    bit_l   <= pdm_in;
                    valid_l <= 1'b1;
                end
                if (rise) begin
                    bit_r   <= pdm_in;
                    valid_r <= 1'b1;
                end
            end
        end
    end

    assign running = (state == ST_RUN);

endmodule

// File: tb/tb_mic_clk_ctrl.sv
// Self-checking bench for mic_clk_ctrl: reset, wake-up timing, capture, stop, divider change, reset in run.
module tb_mic_clk_ctrl;
    import mic_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [15:0] cfg_wdata = '0;
    logic [15:0] cfg_rdata;
    logic        pdm_in = 1'b0;
    logic        micclk, bit_l, bit_r, valid_l, valid_r, running;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic left;
        logic b;
    } cap_t;
    cap_t sb_q[$];

    mic_clk_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .pdm_in    (pdm_in),
        .micclk    (micclk),
        .bit_l     (bit_l),
        .bit_r     (bit_r),
        .valid_l   (valid_l),
        .valid_r   (valid_r),
        .running   (running)
    );

    always #5 clk = ~clk;

    // All tasks are entered and left just after a falling clock edge.
    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [15:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic wait_running();
        int n = 0;
        while (!running && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!running) begin
            errors++;
            $display("FAIL wait_running timeout running=%0b exp 1", running);
        end
    endtask

    task automatic wait_idle();
        logic [15:0] st;
        int n = 0;
        cfg_read(ADDR_STATUS, st);
        while (st != 16'h0 && n < 200) begin
            @(negedge clk);
            cfg_read(ADDR_STATUS, st);
            n++;
        end
        checks++;
        if (st !== 16'h0 || micclk !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle timeout status=%0h micclk=%0b exp 0/0", st, micclk);
        end
    endtask

    task automatic test_reset();
        logic [15:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({micclk, bit_l, bit_r, valid_l, valid_r, running} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 000000", {micclk, bit_l, bit_r, valid_l, valid_r, running});
        end
        rst = 1'b0;
        cfg_read(ADDR_CTRL, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL reset_ctrl got %h exp 0000", d); end
        cfg_read(ADDR_DIV, d);
        checks++;
        if (d !== 16'h0003) begin errors++; $display("FAIL reset_div got %h exp 0003", d); end
        cfg_read(ADDR_WAKE, d);
        checks++;
        if (d !== 16'h0400) begin errors++; $display("FAIL reset_wake got %h exp 0400", d); end
        cfg_read(ADDR_STATUS, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL reset_status got %h exp 0000", d); end
        @(negedge clk);
    endtask

    task automatic test_wakeup();
        int rise1 = -1, rise2 = -1, run_k = -1, vl_k = -1, early = 0;
        logic prev = 1'b0;
        cfg_write(ADDR_DIV, 16'd3);
        cfg_write(ADDR_WAKE, 16'd2);
        cfg_write(ADDR_CTRL, 16'd1);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (micclk && !prev) begin
                if (rise1 < 0) rise1 = k;
                else if (rise2 < 0) rise2 = k;
            end
            if (running && run_k < 0) run_k = k;
            if (valid_l && vl_k < 0) vl_k = k;
            if ((valid_l || valid_r) && k < 17) early++;
            prev = micclk;
        end
        checks++;
        if (rise1 !== 5) begin errors++; $display("FAIL wake_first_rise got %0d exp 5", rise1); end
        checks++;
        if (rise2 - rise1 !== 8) begin errors++; $display("FAIL wake_period got %0d exp 8", rise2 - rise1); end
        checks++;
        if (run_k !== 13) begin errors++; $display("FAIL wake_running got %0d exp 13", run_k); end
        checks++;
        if (vl_k !== 17) begin errors++; $display("FAIL wake_first_valid_l got %0d exp 17", vl_k); end
        checks++;
        if (early !== 0) begin errors++; $display("FAIL wake_early_strobes got %0d exp 0", early); end
    endtask

    task automatic test_capture();
        logic exp_m;
        logic d;
        cap_t e;
        cfg_write(ADDR_CTRL, 16'd0);
        wait_idle();
        cfg_write(ADDR_DIV, 16'd0);
        cfg_write(ADDR_WAKE, 16'd1);
        cfg_write(ADDR_CTRL, 16'd1);
        wait_running();
        exp_m = 1'b1;
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (micclk !== exp_m) begin
                errors++;
                $display("FAIL cap_micclk[%0d] got %0b exp %0b", i, micclk, exp_m);
            end
            checks++;
            if (sb_q.size() == 0) begin
                if (valid_l || valid_r) begin
                    errors++;
                    $display("FAIL cap_no_strobe[%0d] got vl=%0b vr=%0b exp 0/0", i, valid_l, valid_r);
                end
            end else begin
                e = sb_q.pop_front();
                if (e.left && (valid_l !== 1'b1 || valid_r !== 1'b0 || bit_l !== e.b)) begin
                    errors++;
                    $display("FAIL cap_left[%0d] got vl=%0b vr=%0b bit_l=%0b exp 1/0/%0b", i, valid_l, valid_r, bit_l, e.b);
                end else if (!e.left && (valid_r !== 1'b1 || valid_l !== 1'b0 || bit_r !== e.b)) begin
                    errors++;
                    $display("FAIL cap_right[%0d] got vl=%0b vr=%0b bit_r=%0b exp 0/1/%0b", i, valid_l, valid_r, bit_r, e.b);
                end
            end
            if (i == 24) break;
            d = (i < 8) ? exp_m : 1'($urandom_range(0, 1));
            pdm_in = d;
            sb_q.push_back('{left: exp_m, b: d});
            exp_m = ~exp_m;
            @(negedge clk);
        end
        pdm_in = 1'b0;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL cap_queue_left got %0d exp 0", sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_clean_stop();
        logic prev;
        logic [15:0] exp_st;
        int n = 0;
        cfg_write(ADDR_DIV, 16'd3);
        repeat (10) @(negedge clk);
        prev = micclk;
        @(negedge clk);
        while (!(micclk && !prev) && n < 40) begin
            prev = micclk;
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(micclk && !prev) || !running) begin
            errors++;
            $display("FAIL stop_find_rise got micclk=%0b running=%0b exp 1/1", micclk, running);
        end
        cfg_we    = 1'b1;
        cfg_addr  = ADDR_CTRL;
        cfg_wdata = 16'd0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            cfg_we   = 1'b0;
            cfg_addr = ADDR_STATUS;
            #1;
            exp_st = (k == 1) ? 16'h0001 : (k < 4) ? 16'h0004 : 16'h0000;
            checks++;
            if (micclk !== (k < 4)) begin
                errors++;
                $display("FAIL stop_micclk[%0d] got %0b exp %0b", k, micclk, k < 4);
            end
            checks++;
            if (cfg_rdata !== exp_st) begin
                errors++;
                $display("FAIL stop_status[%0d] got %h exp %h", k, cfg_rdata, exp_st);
            end
            checks++;
            if (valid_l || valid_r) begin
                errors++;
                $display("FAIL stop_strobe[%0d] got vl=%0b vr=%0b exp 0/0", k, valid_l, valid_r);
            end
        end
    endtask

    task automatic test_div_change();
        logic exp_m, exp_vl, exp_vr;
        logic [15:0] d;
        cfg_write(ADDR_CTRL, 16'd1);
        wait_running();
        for (int k = 0; k < 12; k++) begin
            if (k == 0) begin
                cfg_we = 1'b1; cfg_addr = ADDR_DIV; cfg_wdata = 16'd1;
            end else begin
                cfg_we = 1'b0;
            end
            exp_m  = (k < 4) ? 1'b1 : (((k - 4) / 2) % 2 == 1);
            exp_vl = (k == 4 || k == 8);
            exp_vr = (k == 6 || k == 10);
            checks++;
            if (micclk !== exp_m) begin
                errors++;
                $display("FAIL div_micclk[%0d] got %0b exp %0b", k, micclk, exp_m);
            end
            checks++;
            if (valid_l !== exp_vl || valid_r !== exp_vr) begin
                errors++;
                $display("FAIL div_strobes[%0d] got %0b%0b exp %0b%0b", k, valid_l, valid_r, exp_vl, exp_vr);
            end
            @(negedge clk);
        end
        cfg_read(ADDR_DIV, d);
        checks++;
        if (d !== 16'h0001) begin errors++; $display("FAIL div_readback got %h exp 0001", d); end
    endtask

    task automatic test_reset_in_run();
        logic [15:0] d;
        int n = 0;
        while (!micclk && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (micclk !== 1'b1 || running !== 1'b1) begin
            errors++;
            $display("FAIL rstrun_pre got micclk=%0b running=%0b exp 1/1", micclk, running);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({micclk, bit_l, bit_r, valid_l, valid_r, running} !== 6'b0) begin
            errors++;
            $display("FAIL rstrun_outputs got %b exp 000000", {micclk, bit_l, bit_r, valid_l, valid_r, running});
        end
        rst = 1'b0;
        cfg_read(ADDR_STATUS, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL rstrun_status got %h exp 0000", d); end
        cfg_read(ADDR_DIV, d);
        checks++;
        if (d !== 16'h0003) begin errors++; $display("FAIL rstrun_div got %h exp 0003", d); end
        cfg_read(ADDR_WAKE, d);
        checks++;
        if (d !== 16'h0400) begin errors++; $display("FAIL rstrun_wake got %h exp 0400", d); end
        cfg_read(ADDR_CTRL, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL rstrun_ctrl got %h exp 0000", d); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (micclk !== 1'b0 || running !== 1'b0) begin
                errors++;
                $display("FAIL rstrun_idle[%0d] got micclk=%0b running=%0b exp 0/0", k, micclk, running);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_wakeup();
        test_capture();
        test_clean_stop();
        test_div_change();
        test_reset_in_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached exp finish");
        $fatal(1);
    end

endmodule

// File: doc/mic_clk_ctrl.md
# mic_clk_ctrl

Configurable controller for the MEMS microphone clock and PDM capture path. It holds a small register file for divider, enable and wake-up time, and runs a clock-generation state machine. It drives the microphone clock without runt pulses, blocks data until the microphones have settled, and captures one left/right stereo PDM bit pair per clock period. It sits between the bus-side configuration interface and the PDM decimation filters.

## Interface
- `CNT_W`, 8: divider counter / DIV register width.
- `WAKE_W`, 16: wake-up counter / WAKE register width.
- Reset is `rst`, synchronous, active-high. Clock is `clk`.
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset.
- `cfg_we` in 1: register write strobe, one cycle per write.
- `cfg_addr` in 2: register address; 0=CTRL, 1=DIV, 2=WAKE, 3=STATUS (read-only).
- `cfg_wdata` in 16: write data.
- `cfg_rdata` out 16: combinational read of the register at `cfg_addr`.
- `pdm_in` in 1: shared L/R PDM data line.
- `micclk` out 1: microphone clock, registered.
- `bit_l` out 1: captured left bit.
- `bit_r` out 1: captured right bit.
- `valid_l` out 1: one-cycle strobe when `bit_l` is new.
- `valid_r` out 1: one-cycle strobe when `bit_r` is new.
- `running` out 1: high while in the RUN state.

## Operation
- **CTRL register:** bit0 is `en`; other bits read 0.
- **DIV register:** bits [CNT_W-1:0] hold `limit`, which is a half-period of `limit+1` clk cycles. The value 0 is legal and gives a `micclk` period of 2 clk cycles.
- **WAKE register:** the number of `micclk` rising edges to wait before data is valid.
- **STATUS register:** {13'b0, stopping, waking, running}.
- **Divider:** counts 0..`limit_act`, then wraps to 0. The `tgl` pulse is asserted when count equals `limit_act`, and `micclk` inverts on that edge.
- **DIV shadowing:** a write to DIV updates the shadow register immediately. `limit_act` loads from the shadow only on a `tgl` cycle, or while in IDLE. If the counter is above the new limit, it still wraps only at `limit_act`.
- **FSM states:**
  - IDLE: counter held at 0, `micclk`=0.
  - WAKE: counter runs. The wake counter increments on each rising toggle. When it reaches WAKE, the FSM moves to RUN on that same edge. If WAKE=0, the FSM goes IDLE→RUN directly.
  - RUN: PDM capture is enabled.
  - STOP: counter keeps running until the next `tgl` that drives `micclk` to 0, then the FSM enters IDLE.
- **Transitions:**
  - IDLE→WAKE (or →RUN) on the edge where `en`=1 is first seen.
  - WAKE/RUN→STOP on the edge where `en`=0 is seen.
  - If `micclk` is already 0 in that cycle and `tgl`=0, the FSM goes straight to IDLE.
  - STOP→WAKE if `en` returns to 1 before IDLE is reached. The wake counter restarts from 0.
- **Capture in RUN:**
  - On a falling toggle (`micclk` 1→0), `pdm_in` is captured into `bit_l`.
  - On a rising toggle, `pdm_in` is captured into `bit_r`.
  - The matching `valid_*` strobe goes high for exactly one cycle.
  - Outside RUN, both strobes are held at 0 and `bit_*` keep their last value.
- **Reset values:** CTRL=0, DIV=3, WAKE=16'h0400, state IDLE. `micclk`, `bit_l`, `bit_r`, `valid_l`, `valid_r` and `running` are all 0.
- **Reset mid-operation:** forces all of the above within one cycle. A runt pulse on `micclk` is accepted only in this case.

## Timing
- Register writes take effect on the edge after the `cfg_we` edge. `cfg_rdata` has zero latency.
- The first `micclk` rise occurs `limit+1` cycles after the FSM leaves IDLE.
- The `micclk` period is `2*(limit_act+1)` clk cycles.
- `bit_*`/`valid_*` are registered on the toggle edge, so they are coincident with the new `micclk` level.
- `pdm_in` is sampled in the cycle before the toggle edge.
- `running` rises on the same edge as the WAKE-th rising toggle. The first strobe is `valid_l` at the following falling toggle.

## Structure
- **Package `mic_pkg`:** state enum (IDLE, WAKE, RUN, STOP), register address constants, and reset defaults for DIV and WAKE.
- **Sub-module `mic_clk_div`:** takes `clk`, `rst`, `run` and `limit_act`, and produces `micclk` and `tgl`/`rise`/`fall` pulses.
- **Top level:** register file, FSM, wake counter and capture flops.

## Test plan
- **Reset:** apply `rst` → all outputs are 0, and reads return CTRL=0, DIV=3, WAKE=0x0400, STATUS=0.
- **Wake-up:** DIV=3, WAKE=2, CTRL=1 →
  - `micclk` period is 8 cycles.
  - `running` rises at the 2nd rising edge.
  - The first `valid_l` follows 4 cycles later.
  - No strobes occur before that.
- **Capture:** DIV=0 in RUN with `pdm_in` driven 1 during high phases and 0 during low phases → `bit_l`=1 and `bit_r`=0 on alternating cycles, each with its strobe.
- **Clean stop:** CTRL=0 written during a `micclk` high phase (DIV=3) →
  - `micclk` stays high until its half-period completes, then stays 0.
  - STATUS shows stopping in between.
  - No strobes are issued after the write.
- **DIV change in RUN:** DIV changed from 3 to 1 mid-half-period → the current half-period stays 4 cycles, and subsequent half-periods are 2 cycles.
- **Reset in RUN:** `rst` asserted while `micclk`=1 → `micclk`=0 and state IDLE on the next edge, and registers return to their defaults.
